// File: rtl/packet_buffer_reader_pkg.sv
// Shared constants and types for the packet buffer read path.
// Also holds the reader's FIFO headroom beyond the RAM read latency.
package packet_buffer_reader_pkg;

  localparam int unsigned BYTE_LEN                       = 8;
  localparam int unsigned PACKET_BUFFER_SIZE             = 2048;
  localparam int unsigned PACKET_BUFFER_READ_LATENCY     = 2;
  localparam int unsigned PACKET_READER_FIFO_DEPTH_EXTRA = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } reader_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous show-ahead FIFO with a registered head entry backed by a small ring.
// Push and pop may occur together in any fill state, including full and empty.
module byte_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  occupancy_o
);

  localparam int unsigned RingDepth = Depth - 1;
  localparam int unsigned PtrW      = (RingDepth > 1) ? $clog2(RingDepth) : 1;
  localparam int unsigned RCntW     = $clog2(RingDepth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(RingDepth - 1);

  logic [Width-1:0] ring_q [RingDepth];
  logic [Width-1:0] head_q, head_d;
  logic             valid_q, valid_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RCntW-1:0] rcnt_q, rcnt_d;
  logic             ring_push, ring_pop, load_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    head_d    = head_q;
    valid_d   = valid_q;
    ring_push = 1'b0;
    ring_pop  = 1'b0;
    load_head = ~valid_q | pop_i;
    if (load_head) begin
      if (rcnt_q != '0) begin
        head_d    = ring_q[rd_ptr_q];
        valid_d   = 1'b1;
        ring_pop  = 1'b1;
        ring_push = push_i;
      end else if (push_i) begin
        // Empty ring: the incoming byte bypasses straight into the head register.
        head_d  = data_i;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      ring_push = push_i;
    end
    wr_ptr_d = ring_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = ring_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    rcnt_d   = rcnt_q + RCntW'(ring_push) - RCntW'(ring_pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q   <= '0;
      valid_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rcnt_q   <= '0;
    end else begin
      head_q   <= head_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rcnt_q   <= rcnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ring_push) begin
      ring_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = head_q;
  assign occupancy_o = CntW'(rcnt_q) + CntW'(valid_q);

endmodule

// File: rtl/packet_buffer_reader.sv
// Streams a wrapping byte range out of the packet buffer RAM as a valid/ready stream.
// Reads are issued only against free FIFO credit so backpressure never loses a byte.
module packet_buffer_reader
  import packet_buffer_reader_pkg::*;
#(
  parameter int unsigned RAM_SIZE     = PACKET_BUFFER_SIZE,
  parameter int unsigned READ_LATENCY = PACKET_BUFFER_READ_LATENCY
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [$clog2(RAM_SIZE)-1:0]     start_addr,
  input  logic [$clog2(RAM_SIZE + 1)-1:0] start_len,
  output logic                            busy,
  output logic                            done,
  output logic                            read_req,
  output logic [$clog2(RAM_SIZE)-1:0]     read_addr,
  input  logic                            read_ready,
  input  logic [BYTE_LEN-1:0]             read_out,
  output logic                            out_valid,
  output logic [BYTE_LEN-1:0]             out_data,
  output logic                            out_last,
  input  logic                            out_ready
);

  localparam int unsigned AddrW     = $clog2(RAM_SIZE);
  localparam int unsigned LenW      = $clog2(RAM_SIZE + 1);
  localparam int unsigned FifoDepth = READ_LATENCY + PACKET_READER_FIFO_DEPTH_EXTRA;
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam int unsigned GuardW    = $clog2(READ_LATENCY + 1);
  localparam logic [AddrW-1:0] AddrLast   = AddrW'(RAM_SIZE - 1);
  localparam logic [CntW:0]    CreditMax  = (CntW + 1)'(FifoDepth);

  reader_state_e     state_q, state_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [LenW-1:0]   issued_q, issued_d;
  logic [LenW-1:0]   popped_q, popped_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic              done_q, done_d;

  logic [CntW-1:0] fifo_occ;
  logic            push, pop, credit_ok;

  // Returns with nothing outstanding are stale data from before reset.
  assign push      = read_ready & (inflight_q != '0);
  assign pop       = out_valid & out_ready;
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_occ}) < CreditMax;

  byte_fifo #(
    .Depth(FifoDepth),
    .Width(BYTE_LEN)
  ) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .data_i     (read_out),
    .pop_i      (pop),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .occupancy_o(fifo_occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= '0;
      guard_q    <= GuardW'(READ_LATENCY);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      inflight_q <= inflight_d;
      guard_q    <= guard_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    popped_d   = popped_q + LenW'(pop);
    inflight_d = inflight_q + CntW'(read_req) - CntW'(push);
    guard_d    = (guard_q != '0) ? guard_q - GuardW'(1) : guard_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && (guard_q == '0)) begin
          addr_d   = start_addr;
          len_d    = start_len;
          issued_d = '0;
          popped_d = '0;
          if (start_len != '0) begin
            state_d = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (read_req) begin
          addr_d   = (addr_q == AddrLast) ? '0 : addr_q + AddrW'(1);
          issued_d = issued_q + LenW'(1);
          if (issued_q == len_q - LenW'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = done_q;
    read_req  = (state_q == StIssue) && (issued_q != len_q) && credit_ok && !reset;
    read_addr = addr_q;
    out_last  = out_valid && (popped_q == len_q - LenW'(1));
  end

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Directed bench for packet_buffer_reader against a fixed-latency RAM driver model
// whose memory holds mem[i] = i[7:0] and whose delay line is never reset.
module tb_packet_buffer_reader;

  localparam int unsigned Lat = 2;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        start      = 1'b0;
  logic [10:0] start_addr = '0;
  logic [11:0] start_len  = '0;
  logic        busy, done, read_req, read_ready, out_valid, out_last;
  logic [10:0] read_addr;
  logic [7:0]  read_out, out_data;
  logic        out_ready  = 1'b1;

  packet_buffer_reader #(
    .RAM_SIZE    (2048),
    .READ_LATENCY(Lat)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .start_len (start_len),
    .busy      (busy),
    .done      (done),
    .read_req  (read_req),
    .read_addr (read_addr),
    .read_ready(read_ready),
    .read_out  (read_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM driver model: read_ready/read_out appear Lat cycles after read_req.
  logic        pipe_v [Lat] = '{default: 1'b0};
  logic [10:0] pipe_a [Lat] = '{default: 11'd0};
  always @(posedge clk) begin
    pipe_v[0] <= read_req;
    pipe_a[0] <= read_addr;
    for (int i = 1; i < Lat; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign read_ready = pipe_v[Lat-1];
  assign read_out   = pipe_a[Lat-1][7:0];

  int n_checks = 0;
  int n_bad    = 0;
  int t0       = 0;
  int rdy_mode = 0;

  int req_a[$], req_t[$], byt_d[$], byt_t[$], byt_l[$], done_t[$];
  int outstanding, max_out, hold_bad, rel_m;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      rel_m = cyc - t0;
      if (read_req) begin
        req_a.push_back(int'(read_addr));
        req_t.push_back(rel_m);
        outstanding++;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (prev_stall && !(out_valid && (out_data == prev_data))) hold_bad++;
      if (out_valid && out_ready) begin
        byt_d.push_back(int'(out_data));
        byt_t.push_back(rel_m);
        byt_l.push_back(int'(out_last));
        outstanding--;
      end
      if (done) done_t.push_back(rel_m);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 0) begin
        out_ready = 1'b1;
      end else begin
        int r;
        r = cyc - t0;
        out_ready = (r >= 6 && r <= 25) ? 1'b0 : r[0];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clear_log();
    req_a.delete(); req_t.delete(); byt_d.delete(); byt_t.delete();
    byt_l.delete(); done_t.delete();
    outstanding = 0; max_out = 0; hold_bad = 0;
  endtask

  task automatic do_start(input int addr, input int len, input bit clr);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = 11'(addr);
    start_len  = 12'(len);
    t0         = cyc;
    if (clr) clear_log();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  // Compares the logged stream against (addr + i) mod 2048, low byte, with last on the final one.
  task automatic check_stream(input string tag, input int addr, input int len);
    int errs;
    errs = 0;
    for (int i = 0; i < len; i++) begin
      int e;
      e = ((addr + i) % 2048) % 256;
      if (q_at(req_a, i) != (addr + i) % 2048) errs++;
      if (q_at(byt_d, i) != e) errs++;
      if (q_at(byt_l, i) != ((i == len - 1) ? 1 : 0)) errs++;
    end
    check_eq({tag, "_nreq"}, 32'(req_a.size()), 32'(len));
    check_eq({tag, "_nbyte"}, 32'(byt_d.size()), 32'(len));
    check_eq({tag, "_content_errs"}, 32'(errs), 32'd0);
  endtask

  initial begin
    int n;
    clear_log();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_read_req", 32'(read_req), 32'd0);
    check_eq("rst_read_addr", 32'(read_addr), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // 1: basic 4-byte job with exact cycle timing.
    do_start(16, 4, 1'b1);
    wait_done("t1_done_seen", 30);
    repeat (3) @(posedge clk);
    check_stream("t1", 16, 4);
    check_eq("t1_first_req_t", 32'(q_at(req_t, 0)), 32'd1);
    check_eq("t1_last_req_t", 32'(q_at(req_t, 3)), 32'd4);
    check_eq("t1_first_byte_t", 32'(q_at(byt_t, 0)), 32'd4);
    check_eq("t1_last_byte_t", 32'(q_at(byt_t, 3)), 32'd7);
    check_eq("t1_done_t", 32'(q_at(done_t, 0)), 32'd8);
    check_eq("t1_done_count", 32'(done_t.size()), 32'd1);
    check_eq("t1_busy_after", 32'(busy), 32'd0);

    // 2: address wrap at the end of the buffer.
    do_start(2046, 4, 1'b1);
    wait_done("t2_done_seen", 30);
    check_stream("t2", 2046, 4);
    check_eq("t2_byte2", 32'(q_at(byt_d, 2)), 32'h00);
    check_eq("t2_byte1", 32'(q_at(byt_d, 1)), 32'hFF);

    // 3: backpressure with a 20-cycle stall.
    rdy_mode = 1;
    do_start(100, 10, 1'b1);
    wait_done("t3_done_seen", 200);
    rdy_mode = 0;
    check_stream("t3", 100, 10);
    check_eq("t3_max_credit", 32'(max_out), 32'd4);
    n = 0;
    foreach (req_t[i]) if (req_t[i] >= 12 && req_t[i] <= 25) n++;
    check_eq("t3_req_in_stall", 32'(n), 32'd0);
    check_eq("t3_hold_violations", 32'(hold_bad), 32'd0);

    // 4a: zero-length job.
    do_start(7, 0, 1'b1);
    wait_done("t4a_done_seen", 5);
    repeat (4) @(posedge clk);
    check_eq("t4a_done_t", 32'(q_at(done_t, 0)), 32'd1);
    check_eq("t4a_done_count", 32'(done_t.size()), 32'd1);
    check_eq("t4a_nreq", 32'(req_a.size()), 32'd0);
    check_eq("t4a_nbyte", 32'(byt_d.size()), 32'd0);

    // 4b: start while busy is ignored.
    do_start(50, 6, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b1; start_addr = 11'd900; start_len = 12'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t4b_done_seen", 40);
    repeat (6) @(posedge clk);
    check_stream("t4b", 50, 6);
    check_eq("t4b_done_t", 32'(q_at(done_t, 0)), 32'd10);
    check_eq("t4b_done_count", 32'(done_t.size()), 32'd1);
    check_eq("t4b_busy_after", 32'(busy), 32'd0);

    // 5: reset mid-job, guarded start, then a clean retry.
    do_start(0, 100, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_log();
    t0 = cyc;
    start = 1'b1; start_addr = 11'd0; start_len = 12'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("t5_guard_busy", 32'(busy), 32'd0);
    do_start(0, 3, 1'b0);
    wait_done("t5_done_seen", 30);
    repeat (4) @(posedge clk);
    check_stream("t5", 0, 3);
    check_eq("t5_done_t", 32'(q_at(done_t, 0)), 32'd7);

    // 6: full-buffer job at full rate, then back-to-back start on the done cycle.
    do_start(5, 2048, 1'b1);
    wait_done("t6_done_seen", 2200);
    check_stream("t6", 5, 2048);
    check_eq("t6_last_byte", 32'(q_at(byt_d, 2047)), 32'h04);
    check_eq("t6_byte_span", 32'(q_at(byt_t, 2047) - q_at(byt_t, 0)), 32'd2047);
    check_eq("t6_req_span", 32'(q_at(req_t, 2047) - q_at(req_t, 0)), 32'd2047);
    start = 1'b1; start_addr = 11'd300; start_len = 12'd2;
    t0 = cyc;
    clear_log();
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("t6b_busy", 32'(busy), 32'd1);
    wait_done("t6b_done_seen", 30);
    check_stream("t6b", 300, 2);
    check_eq("t6b_first_byte", 32'(q_at(byt_d, 0)), 32'h2C);
    check_eq("t6b_done_t", 32'(q_at(done_t, 0)), 32'd6);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1);
  end

endmodule
